// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the time-division demultiplexer and its
// companion multiplexer: FSM state encoding, lane count, lane slicing.
package tdm_demux_pkg;

  localparam int S_DEF = 2;
  localparam int M_DEF = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Number of lanes carried by an S-bit select.
  function automatic int n_lanes(input int s);
    return 32'sd1 << s;
  endfunction

  // Low bit offset of lane i in a packed bus of m-bit lanes.
  function automatic int lane_lo(input int i, input int m);
    return m * i;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Serial-in / packed-frame-out bundle between a word source and tdm_demux.
interface tdm_demux_if
  import tdm_demux_pkg::*;
#(
  parameter int S = S_DEF,
  parameter int M = M_DEF
) ();

  logic [M-1:0]            din;
  logic                    din_valid;
  logic                    sof;
  logic [M*n_lanes(S)-1:0] dout;
  logic                    dout_valid;
  logic [S-1:0]            slot;
  logic                    frame_err;

  // Word source side.
  modport master (
    output din, din_valid, sof,
    input  dout, dout_valid, slot, frame_err
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, sof,
    output dout, dout_valid, slot, frame_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Lane index counter: clear, load-1 (frame start) or increment, with a flag
// marking the last lane. It never wraps on its own; the FSM clears it.
module tdm_slot_ctr #(
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld1,
  input  logic         inc,
  output logic [S-1:0] slot,
  output logic         last
);

  logic [S-1:0] cnt_r;

  // Counter register; clear wins over load-1, load-1 over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {S{1'b0}};
    end else if (clr) begin
      cnt_r <= {S{1'b0}};
    end else if (ld1) begin
      cnt_r <= S'(1'b1);
    end else if (inc) begin
      cnt_r <= cnt_r + S'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign slot = cnt_r;
  assign last = (cnt_r == {S{1'b1}});

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects N = 2**S serial M-bit words framed by
// sof into shadow lanes and publishes the whole packed frame in one cycle.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int S = S_DEF,
  parameter int M = M_DEF
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  localparam int N = n_lanes(S);
  localparam int W = M * N;

  state_e       state_r;
  logic [M-1:0] shadow_r [N];
  logic [W-1:0] dout_r;
  logic         dout_valid_r;
  logic         frame_err_r;

  logic [S-1:0] slot_s;
  logic         last_s;
  logic         clr_s;
  logic         ld1_s;
  logic         inc_s;
  logic [W-1:0] frame_s;

  // Slot counter control mirrors the FSM's word-acceptance decisions.
  always_comb begin
    clr_s = 1'b0;
    ld1_s = 1'b0;
    inc_s = 1'b0;
    if (bus.din_valid) begin
      if (bus.sof) begin
        ld1_s = 1'b1;
      end else if (state_r == FILL) begin
        if (last_s) begin
          clr_s = 1'b1;
        end else begin
          inc_s = 1'b1;
        end
      end else begin
        clr_s = 1'b0;
      end
    end else begin
      inc_s = 1'b0;
    end
  end

  tdm_slot_ctr #(.S(S)) u_slot_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .ld1  (ld1_s),
    .inc  (inc_s),
    .slot (slot_s),
    .last (last_s)
  );

  // Candidate published frame: shadow lanes 0..N-2 plus the incoming last word.
  always_comb begin
    frame_s = {W{1'b0}};
    for (int i = 0; i < N - 1; i++) begin
      frame_s[lane_lo(i, M) +: M] = shadow_r[i];
    end
    frame_s[lane_lo(N - 1, M) +: M] = bus.din;
  end

  // Framing FSM, shadow lane bank and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      dout_r       <= {W{1'b0}};
      dout_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_r[i] <= {M{1'b0}};
      end
    end else begin
      dout_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.din_valid) begin
            if (bus.sof) begin
              shadow_r[0] <= bus.din;
              state_r     <= FILL;
            end else begin
              // Stray word outside a frame is dropped.
              frame_err_r <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.din_valid) begin
            if (bus.sof) begin
              // Restart: discard the partial frame, this word becomes lane 0.
              frame_err_r <= 1'b1;
              shadow_r[0] <= bus.din;
            end else if (last_s) begin
              dout_r       <= frame_s;
              dout_valid_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              shadow_r[slot_s] <= bus.din;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.slot       = slot_s;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed plus randomized bench for tdm_demux (S=2, M=3) with a
// frame-collecting reference model built on a word queue.
module tb_tdm_demux;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pub_q[$];

  // Reference model state.
  bit         m_busy;
  logic [2:0] m_words[$];
  logic [11:0] m_dout;
  logic       m_dv;
  logic       m_fe;

  tdm_demux_if #(.S(2), .M(3)) bus ();

  tdm_demux #(.S(2), .M(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare outputs.
  task automatic step(input logic r, input logic v, input logic s, input logic [2:0] d);
    logic [11:0] exp_slot;
    rst = r;
    bus.din_valid = v;
    bus.sof = s;
    bus.din = d;
    @(posedge clk);
    cyc++;
    m_dv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_busy = 1'b0;
      m_words.delete();
      m_dout = 12'h000;
    end else if (v) begin
      if (s) begin
        if (m_busy) m_fe = 1'b1;
        m_words.delete();
        m_words.push_back(d);
        m_busy = 1'b1;
      end else if (!m_busy) begin
        m_fe = 1'b1;
      end else begin
        m_words.push_back(d);
        if (m_words.size() == 4) begin
          for (int i = 0; i < 4; i++) m_dout[3*i +: 3] = m_words[i];
          m_dv = 1'b1;
          m_words.delete();
          m_busy = 1'b0;
        end
      end
    end
    #1;
    exp_slot = m_busy ? 12'(m_words.size()) : 12'h000;
    chk("dout", bus.dout, m_dout);
    chk("dout_valid", {11'd0, bus.dout_valid}, {11'd0, m_dv});
    chk("frame_err", {11'd0, bus.frame_err}, {11'd0, m_fe});
    chk("slot", {10'd0, bus.slot}, exp_slot);
    if (bus.dout_valid === 1'b1) pub_q.push_back(cyc);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    logic [2:0] w;
    int p0;
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.din = 3'd0;
    m_busy = 1'b0;
    m_dout = 12'h000;
    m_dv = 1'b0;
    m_fe = 1'b0;

    // 1: reset held with din_valid toggling
    step(1'b1, 1'b1, 1'b1, 3'd5);
    step(1'b1, 1'b0, 1'b0, 3'd2);
    chk("t1_dout", bus.dout, 12'h000);

    // 2: contiguous frame 1,2,3,4
    step(1'b0, 1'b1, 1'b1, 3'd1);
    step(1'b0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b1, 1'b0, 3'd4);
    chk("t2_dout", bus.dout, 12'h8D1);
    chk("t2_dv", {11'd0, bus.dout_valid}, 12'h001);
    gap(1);
    chk("t2_dv_off", {11'd0, bus.dout_valid}, 12'h000);

    // 3: same frame with random gaps
    step(1'b0, 1'b1, 1'b1, 3'd1);
    gap($urandom_range(0, 3));
    step(1'b0, 1'b1, 1'b0, 3'd2);
    gap($urandom_range(0, 3));
    step(1'b0, 1'b1, 1'b0, 3'd3);
    gap($urandom_range(0, 3));
    step(1'b0, 1'b1, 1'b0, 3'd4);
    chk("t3_dout", bus.dout, 12'h8D1);
    gap(2);

    // 4: restart mid-frame
    step(1'b0, 1'b1, 1'b1, 3'd1);
    step(1'b0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b1, 1'b1, 3'd5);
    chk("t4_err", {11'd0, bus.frame_err}, 12'h001);
    step(1'b0, 1'b1, 1'b0, 3'd6);
    step(1'b0, 1'b1, 1'b0, 3'd7);
    step(1'b0, 1'b1, 1'b0, 3'd0);
    chk("t4_dout", bus.dout, 12'h1F5);

    // 5: stray word in IDLE, then a normal frame
    step(1'b0, 1'b1, 1'b0, 3'd6);
    chk("t5_err", {11'd0, bus.frame_err}, 12'h001);
    chk("t5_hold", bus.dout, 12'h1F5);
    step(1'b0, 1'b1, 1'b1, 3'd7);
    step(1'b0, 1'b1, 1'b0, 3'd6);
    step(1'b0, 1'b1, 1'b0, 3'd5);
    step(1'b0, 1'b1, 1'b0, 3'd4);

    // 6: back-to-back frames, pulses exactly 4 cycles apart
    pub_q.delete();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        w = 3'($urandom_range(0, 7));
        step(1'b0, 1'b1, (i == 0), w);
      end
    end
    chk("t6_npub", 12'(pub_q.size()), 12'd2);
    p0 = (pub_q.size() == 2) ? pub_q[1] - pub_q[0] : 0;
    chk("t6_spacing", 12'(p0), 12'd4);

    // 7: reset mid-frame, then a fresh frame
    step(1'b0, 1'b1, 1'b1, 3'd3);
    step(1'b0, 1'b1, 1'b0, 3'd3);
    step(1'b1, 1'b1, 1'b0, 3'd1);
    chk("t7_dout_rst", bus.dout, 12'h000);
    step(1'b0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b1, 1'b1, 3'd1);
    step(1'b0, 1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b1, 1'b0, 3'd4);
    chk("t7_dout", bus.dout, 12'h8D1);

    // Randomized traffic: sparse sof, gaps, rare resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential counterpart of the parameterized 2**S-to-1 multiplexer: a time-division demultiplexer that takes a serial stream of M-bit words and distributes them into 2**S lanes.
- Words arrive one per valid cycle, framed by a start-of-frame flag.
- The block assembles the packed lane bus and publishes it once per complete frame.
- The packed layout matches the multiplexer's din bus, so a mux → serial link → tdm_demux chain round-trips the data.

Parameters:
- S, 2, select width; number of lanes N = 2**S; S >= 1 required.
- M, 3, bits per data word / lane.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  M  serial data word
- din_valid  input  1  din carries a word this cycle
- sof  input  1  qualifies the current valid word as lane 0 of a new frame; ignored when din_valid=0
- dout  output  M*2**S  packed frame; lane i occupies dout[M*i+M-1:M*i]
- dout_valid  output  1  one-cycle pulse: dout has just been updated with a complete frame
- slot  output  S  index of the lane the next accepted word fills
- frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (rst=1 at a clock edge), all cleared:
  - state=IDLE, slot=0.
  - dout, dout_valid and frame_err = 0.
  - Shadow lane registers = 0.
- Reset takes priority over all other inputs.
- Reset mid-frame discards the partial frame; dout is cleared to 0.
- States: IDLE (waiting for sof), FILL (collecting lanes 1..N-1).
- IDLE:
  - din_valid&sof: shadow lane0 <= din; slot <= 1; go to FILL.
  - din_valid&~sof: word dropped; frame_err=1 for one cycle; stay in IDLE.
  - din_valid=0: hold.
- FILL:
  - din_valid&~sof: shadow lane[slot] <= din; slot <= slot+1.
  - Word accepted at slot==N-1 publishes the frame:
    - dout <= {din, shadow lanes N-2..0}.
    - dout_valid=1 in the following cycle, for exactly one cycle.
    - slot <= 0; go to IDLE.
  - din_valid&sof: frame_err=1 for one cycle; partial frame discarded; the word restarts a frame (lane0 <= din, slot <= 1, stay in FILL).
  - sof on the slot N-1 word is also treated as a restart; it never publishes.
  - din_valid=0: hold all state; gaps of any length are legal.
- Latency: dout/dout_valid are registered, visible in the cycle after the edge that accepts the final word.
- dout holds the last published frame until the next publish; it is never partially updated.
- Back-to-back frames: sof in the cycle immediately after the final word is accepted (state is IDLE). Sustained throughput is one frame per N valid cycles.
- slot wraps N-1 → 0 only via publish or restart; there is no free-running wrap.
- frame_err and dout_valid never both assert from the same input word.

Decomposition:
- Shared package:
  - State enum {IDLE, FILL}.
  - Constant function n_lanes(S)=2**S.
  - Lane slice helper for M*i offsets, shared with the multiplexer.
- One natural sub-module: tdm_slot_ctr.
  - S-bit counter with clear/load-1/increment and a last-slot flag.
  - The FSM and lane register bank stay in tdm_demux.

Test Plan (S=2, M=3, N=4):
1. Hold rst=1 for 2 cycles with din_valid toggling → dout=12'h000, dout_valid=0, frame_err=0, slot=0.
2. Four consecutive valid words 1(sof),2,3,4 → dout=12'h8D1 and dout_valid=1 for exactly one cycle, one cycle after the 4th word. Then slot=0.
3. Same words with 0-3 idle cycles between them → identical dout=12'h8D1. slot holds during gaps; single dout_valid pulse.
4. Words 1(sof),2,3 then 5(sof),6,7,0:
   - frame_err pulses at word 5.
   - dout=12'h1F5 after word 0.
   - No publish of the aborted frame.
5. In IDLE, word 6 without sof → frame_err pulse, dout keeps the previous value, slot=0. Then a valid frame publishes normally.
6. Two back-to-back frames with no gap → dout_valid pulses spaced exactly 4 cycles apart, correct values each time.
7. Reset mid-frame followed by a fresh frame → dout=0 after reset, then the correct new frame.
